multicycle_controller: RTL
==========================

# multicycle_controller

Sequencing controller for the multi-cycle RV32I core variant: a Moore FSM that steps one shared ALU, one unified instruction/data memory port and the register file through fetch, decode, execute, memory and writeback cycles. It sits beside the multi-cycle datapath and drives all of its write enables and mux selects. Memory accesses use a ready handshake, so fetch and load/store cycles stretch for slow memory. It covers the same instruction subset as the single-cycle decoder (lw, sw, R-type, I-type ALU, beq, jal) and flags unsupported opcodes.

## Interface
- No parameters.
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- Op  in  7  instruction[6:0] from the instruction register
- funct3  in  3  instruction[14:12]
- funct7  in  7  instruction[31:25]
- Zero  in  1  ALU zero flag, same cycle
- MemReady  in  1  memory completes the current access this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address: 0 = PC, 1 = Result
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register and OldPC enable
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = RD1
- ALUSrcB  out  2  00 = RD2, 01 = ImmExt, 10 = constant 4
- ImmSrc  out  2  00 = I, 01 = S, 10 = B, 11 = J
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- RegWrite  out  1  register file write enable
- IllegalOp  out  1  one-cycle pulse on an unsupported opcode
- State  out  4  current state encoding, for debug

## Operation
- **State encodings:** FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BEQ=10. Codes 11–15 are unreachable and go to FETCH.
- **Outputs:** Moore outputs derived from state, except PCWrite = PCUpdate | (Branch & Zero). Any signal not listed for a state is 0. An unlisted ALUOp is add.
- **FETCH:** AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp add, ResultSrc=10. IRWrite and PCUpdate equal MemReady. Go to DECODE if MemReady, else stay.
- **DECODE:** ALUSrcA=01, ALUSrcB=01, add (precomputes the branch target). Next state by Op:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BEQ
  - 1101111 → JAL
  - any other → FETCH, with IllegalOp=1 for this cycle
- **MEMADR:** ALUSrcA=10, ALUSrcB=01, add. Next is MEMREAD if Op=0000011, else MEMWRITE.
- **MEMREAD:** ResultSrc=00, AdrSrc=1. Stay until MemReady, then go to MEMWB.
- **MEMWB:** ResultSrc=01, RegWrite=1. Next is FETCH.
- **MEMWRITE:** ResultSrc=00, AdrSrc=1, MemWrite=1, held until MemReady. Next is FETCH on MemReady.
- **EXECR:** ALUSrcA=10, ALUSrcB=00, ALUOp funct. Next is ALUWB.
- **EXECI:** ALUSrcA=10, ALUSrcB=01, ALUOp funct. Next is ALUWB.
- **ALUWB:** ResultSrc=00, RegWrite=1. Next is FETCH.
- **JAL:** ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCUpdate=1. Next is ALUWB (writes PC+4 to rd).
- **BEQ:** ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, Branch=1. Next is FETCH.
- **ALUOp funct decode:**
  - funct3=000: sub when Op=0110011 and funct7[5]=1; otherwise add (addi ignores funct7)
  - funct3=010 → slt
  - funct3=110 → or
  - funct3=111 → and
  - any other funct3 → add
- **ImmSrc:** combinational from Op in every state. sw → 01, beq → 10, jal → 11, all else → 00.

## Timing
- **Reset:** rst asserted sends State to FETCH immediately, without waiting for a clock edge. While rst=1, PCWrite, IRWrite, MemWrite, RegWrite and IllegalOp are forced to 0. The other outputs show FETCH values.
- **Reset mid-operation:** reset in any state, including a stalled MEMWRITE, aborts with no further write strobes. The first fetch uses the first rising edge after rst deasserts.
- **Instruction latency with MemReady=1:**
  - lw: 5 cycles
  - sw, R-type, I-type, jal: 4 cycles
  - beq: 3 cycles
  - illegal opcode: 2 cycles
- **Memory stalls:** each cycle MemReady is low in FETCH, MEMREAD or MEMWRITE adds one cycle.
- **Write strobes:** PCWrite, IRWrite, RegWrite are single-cycle per instruction. A stall never repeats them. MemWrite stays high for the whole stalled MEMWRITE window.
- **BEQ:** PCWrite is combinational on Zero within the BEQ cycle.

## Test plan
- **Reset:** assert rst mid-clock in EXECR → State=0 before the next edge, all enables 0. Release rst with MemReady=1 → IRWrite=1 and PCWrite=1 on the first cycle.
- **add x3,x1,x2** (Op=0110011, funct3=000, funct7=0000000), MemReady=1 → states 0,1,6,7,0. ALUControl=000 in EXECR. RegWrite=1 only in ALUWB.
- **sub** (funct7=0100000) → ALUControl=001. **addi** with funct7 bits=0100000 → ALUControl=000. funct3=010/110/111 → 101/011/010.
- **lw** with MemReady low for 2 cycles in FETCH and 3 cycles in MEMREAD → total 10 cycles. IRWrite pulses once. RegWrite pulses once in MEMWB with ResultSrc=01.
- **sw** with MemReady low for 2 cycles in MEMWRITE → MemWrite high for 3 consecutive cycles, ImmSrc=01, then FETCH.
- **beq** → Zero=1 gives PCWrite=1 in BEQ, Zero=0 gives PCWrite=0, ImmSrc=10. **jal** → PCWrite in JAL, RegWrite in ALUWB, ImmSrc=11. **Op=1111111** → IllegalOp=1 for one cycle in DECODE, then State=0.

Source files
------------

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore sequencer for the multi-cycle RV32I datapath.
// Steps the shared ALU, unified memory port and register file through
// fetch/decode/execute/memory/writeback, stalling on the memory ready handshake.
module multicycle_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] Op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       RegWrite,
    output logic       IllegalOp,
    output logic [3:0] State
);

    localparam int unsigned STATE_W = 4;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_RTYP = 7'b0110011;
    localparam logic [6:0] OP_ITYP = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [STATE_W-1:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        ALUWB    = 4'd7,
        EXECI    = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [2:0] funct_alu;
    logic       pc_update;
    logic       branch;

    // Only funct7[5] distinguishes sub from add; the other bits are don't-care.
    logic unused_funct7;
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    // ALU operation selected by funct3/funct7 for R-type and I-type execute.
    always_comb begin
        funct_alu = ALU_ADD;
        case (funct3)
            3'b000:  funct_alu = (Op == OP_RTYP && funct7[5]) ? ALU_SUB : ALU_ADD;
            3'b010:  funct_alu = ALU_SLT;
            3'b110:  funct_alu = ALU_OR;
            3'b111:  funct_alu = ALU_AND;
            default: funct_alu = ALU_ADD;
        endcase
    end

    // Immediate format follows the opcode in every state.
    always_comb begin
        ImmSrc = 2'b00;
        case (Op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    // Next-state and Moore output decode; write strobes are masked during reset.
    always_comb begin
        state_d    = state_q;
        pc_update  = 1'b0;
        branch     = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_ADD;
        RegWrite   = 1'b0;
        IllegalOp  = 1'b0;

        case (state_q)
            FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = MemReady;
                pc_update = MemReady;
                if (MemReady) state_d = DECODE;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (Op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYP:      state_d = EXECR;
                    OP_ITYP:      state_d = EXECI;
                    OP_BEQ:       state_d = BEQ;
                    OP_JAL:       state_d = JAL;
                    default: begin
                        state_d   = FETCH;
                        IllegalOp = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = (Op == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                AdrSrc = 1'b1;
                if (MemReady) state_d = MEMWB;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                state_d   = FETCH;
            end
            MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                if (MemReady) state_d = FETCH;
            end
            EXECR: begin
                ALUSrcA    = 2'b10;
                ALUControl = funct_alu;
                state_d    = ALUWB;
            end
            EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = funct_alu;
                state_d    = ALUWB;
            end
            ALUWB: begin
                RegWrite = 1'b1;
                state_d  = FETCH;
            end
            JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
                state_d   = ALUWB;
            end
            BEQ: begin
                ALUSrcA    = 2'b10;
                ALUControl = ALU_SUB;
                branch     = 1'b1;
                state_d    = FETCH;
            end
            default: state_d = FETCH;
        endcase

        PCWrite = pc_update | (branch & Zero);

        if (rst) begin
            PCWrite   = 1'b0;
            IRWrite   = 1'b0;
            MemWrite  = 1'b0;
            RegWrite  = 1'b0;
            IllegalOp = 1'b0;
        end
    end

    // State register; reset returns to FETCH without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= FETCH;
        else     state_q <= state_d;
    end

    assign State = STATE_W'(state_q);

endmodule
